// File: rtl/pinmux_wb_regbus_bridge_if.sv
// Bus bundle between a Wishbone-classic master, the bridge and the pinmux reg-bus slave.
//   slave  : bridge view (WB signals in, reg-bus request out, reg-bus response in)
//   master : environment view (drives WB request and reg-bus response)
// Signal names keep the bridge-relative _i/_o suffixes of the WB side.
interface pinmux_wb_regbus_bridge_if #(
  parameter int unsigned AW = 6
);
  // Wishbone side
  logic          wbd_cyc_i;
  logic          wbd_stb_i;
  logic          wbd_we_i;
  logic [AW-1:0] wbd_adr_i;
  logic [31:0]   wbd_dat_i;
  logic [3:0]    wbd_sel_i;
  logic [31:0]   wbd_dat_o;
  logic          wbd_ack_o;
  logic          wbd_err_o;
  // Register-bus side
  logic          reg_cs;
  logic          reg_wr;
  logic [AW-3:0] reg_addr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_be;
  logic [31:0]   reg_rdata;
  logic          reg_ack;

  modport slave (
    input  wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i, wbd_sel_i,
    output wbd_dat_o, wbd_ack_o, wbd_err_o,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport master (
    output wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i, wbd_sel_i,
    input  wbd_dat_o, wbd_ack_o, wbd_err_o,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/pinmux_wb_regbus_bridge.sv
// Wishbone-classic slave to pinmux reg-bus master.
// Each WB cycle becomes one reg_cs/reg_ack transaction; data or error is returned to WB.
// Out-of-range word indices are errored without touching the reg bus, and an ack timeout
// keeps a stuck or absent register slave from hanging the WB interconnect.
// Ports:
//   mclk    : single clock
//   h_reset : synchronous active-high reset
//   bus     : slave modport of pinmux_wb_regbus_bridge_if (WB slave + reg-bus master)
// All outputs are registered.
module pinmux_wb_regbus_bridge #(
  parameter int unsigned AW        = 6,
  parameter int unsigned NUM_REGS  = 12,
  parameter int unsigned TO_CYCLES = 255
) (
  input logic                           mclk,
  input logic                           h_reset,
  pinmux_wb_regbus_bridge_if.slave      bus
);

  localparam int unsigned IW    = AW - 2;
  localparam logic [7:0]  ToCnt = 8'(TO_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic            reg_cs_q, reg_cs_d;
  logic            reg_wr_q, reg_wr_d;
  logic [IW-1:0]   reg_addr_q, reg_addr_d;
  logic [31:0]     reg_wdata_q, reg_wdata_d;
  logic [3:0]      reg_be_q, reg_be_d;
  logic            wb_ack_q, wb_ack_d;
  logic            wb_err_q, wb_err_d;
  logic [31:0]     wb_dat_q, wb_dat_d;

  logic            req_valid;
  logic [IW-1:0]   req_idx;
  logic            in_range;
  logic [7:0]      cnt_inc;
  logic            timeout;
  logic            abort_now;
  logic            unused_adr;

  assign req_valid  = bus.wbd_cyc_i & bus.wbd_stb_i;
  assign req_idx    = bus.wbd_adr_i[AW-1:2];
  assign in_range   = 32'(req_idx) < NUM_REGS;
  // Byte-lane address bits are not part of the word index.
  assign unused_adr = ^bus.wbd_adr_i[1:0];

  // Saturating count of completed REQ cycles; timeout fires on the edge that completes
  // the TO_CYCLES-th cycle without an ack.
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timeout   = (cnt_inc == ToCnt);
  // Master gave up the cycle at some point during REQ (including this edge).
  assign abort_now = abort_q | ~bus.wbd_cyc_i;

  // State register and all output flops.
  always_ff @(posedge mclk) begin
    if (h_reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      abort_q     <= 1'b0;
      reg_cs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 32'd0;
      reg_be_q    <= 4'd0;
      wb_ack_q    <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_dat_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      reg_cs_q    <= reg_cs_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      wb_ack_q    <= wb_ack_d;
      wb_err_q    <= wb_err_d;
      wb_dat_q    <= wb_dat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) state_d = in_range ? StReq : StResp;
      end
      StReq: begin
        // An abandoned WB cycle skips RESP so no ack/err reaches the master.
        if (bus.reg_ack || timeout) state_d = abort_now ? StIdle : StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    reg_cs_d    = reg_cs_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    wb_ack_d    = 1'b0;
    wb_err_d    = 1'b0;
    wb_dat_d    = wb_dat_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          reg_wr_d    = bus.wbd_we_i;
          reg_addr_d  = req_idx;
          reg_wdata_d = bus.wbd_dat_i;
          reg_be_d    = bus.wbd_sel_i;
          cnt_d       = 8'd0;
          abort_d     = 1'b0;
          if (in_range) reg_cs_d = 1'b1;
          else          wb_err_d = 1'b1;
        end
      end
      StReq: begin
        cnt_d   = cnt_inc;
        abort_d = abort_now;
        // Ack has priority over a coincident timeout.
        if (bus.reg_ack) begin
          reg_cs_d = 1'b0;
          if (!abort_now) begin
            wb_ack_d = 1'b1;
            if (!reg_wr_q) wb_dat_d = bus.reg_rdata;
          end
        end else if (timeout) begin
          reg_cs_d = 1'b0;
          if (!abort_now) wb_err_d = 1'b1;
        end
      end
      StResp: begin
      end
      default: begin
        reg_cs_d = 1'b0;
      end
    endcase
  end

  assign bus.reg_cs    = reg_cs_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_be    = reg_be_q;
  assign bus.wbd_ack_o = wb_ack_q;
  assign bus.wbd_err_o = wb_err_q;
  assign bus.wbd_dat_o = wb_dat_q;

endmodule

// File: tb/tb_pinmux_wb_regbus_bridge.sv
// Directed bench for pinmux_wb_regbus_bridge (TO_CYCLES=4 so the timeout is reachable).
// The bench plays WB master and a one-cycle-latency reg-bus slave.
module tb_pinmux_wb_regbus_bridge;

  logic mclk = 1'b0;
  logic h_reset;
  logic slave_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transfer observations, indexed by negedge count after the request was driven.
  int          cs_cnt, ack_cnt, err_cnt, both_cnt, sack_cnt;
  int          cs_first, ack_at, err_at;
  logic [31:0] rd_seen, wd_seen;
  logic [3:0]  addr_seen, be_seen;
  logic        wr_seen;

  pinmux_wb_regbus_bridge_if #(.AW(6)) bus ();

  pinmux_wb_regbus_bridge #(
    .AW       (6),
    .NUM_REGS (12),
    .TO_CYCLES(4)
  ) u_dut (
    .mclk   (mclk),
    .h_reset(h_reset),
    .bus    (bus)
  );

  always #5 mclk = ~mclk;

  // Registered slave: one-cycle ack pulse one cycle after reg_cs is seen.
  always @(posedge mclk) begin
    if (h_reset) bus.reg_ack <= 1'b0;
    else         bus.reg_ack <= slave_en && bus.reg_cs && !bus.reg_ack;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_obs();
    cs_cnt = 0; ack_cnt = 0; err_cnt = 0; both_cnt = 0; sack_cnt = 0;
    cs_first = -1; ack_at = -1; err_at = -1;
    rd_seen = 32'hDEAD_BEEF; wd_seen = 32'd0; addr_seen = 4'hF; be_seen = 4'd0; wr_seen = 1'b0;
  endtask

  task automatic sample(input int i);
    @(negedge mclk);
    if (bus.reg_ack) sack_cnt++;
    if (bus.reg_cs) begin
      cs_cnt++;
      if (cs_first < 0) begin
        cs_first  = i;
        addr_seen = bus.reg_addr;
        be_seen   = bus.reg_be;
        wr_seen   = bus.reg_wr;
        wd_seen   = bus.reg_wdata;
      end
    end
    if (bus.wbd_ack_o && bus.wbd_err_o) both_cnt++;
    if (bus.wbd_ack_o) begin
      ack_cnt++;
      ack_at  = i;
      rd_seen = bus.wbd_dat_o;
    end
    if (bus.wbd_err_o) begin
      err_cnt++;
      err_at = i;
    end
    // Classic WB master releases the cycle once it sees the termination.
    if (bus.wbd_ack_o || bus.wbd_err_o) begin
      bus.wbd_cyc_i = 1'b0;
      bus.wbd_stb_i = 1'b0;
    end
  endtask

  // Called at a negedge; drives a request and observes 8 cycles.
  task automatic wb_xfer(input logic we, input logic [5:0] adr, input logic [31:0] dat);
    clr_obs();
    bus.wbd_cyc_i = 1'b1;
    bus.wbd_stb_i = 1'b1;
    bus.wbd_we_i  = we;
    bus.wbd_adr_i = adr;
    bus.wbd_dat_i = dat;
    bus.wbd_sel_i = 4'hF;
    for (int i = 1; i <= 8; i++) sample(i);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cs"},    32'(bus.reg_cs),    32'd0);
    check_eq({tag, "_ack"},   32'(bus.wbd_ack_o), 32'd0);
    check_eq({tag, "_err"},   32'(bus.wbd_err_o), 32'd0);
    check_eq({tag, "_dat"},   bus.wbd_dat_o,      32'd0);
    check_eq({tag, "_wr"},    32'(bus.reg_wr),    32'd0);
    check_eq({tag, "_addr"},  32'(bus.reg_addr),  32'd0);
    check_eq({tag, "_wdata"}, bus.reg_wdata,      32'd0);
    check_eq({tag, "_be"},    32'(bus.reg_be),    32'd0);
  endtask

  initial begin
    h_reset       = 1'b1;
    slave_en      = 1'b1;
    bus.wbd_cyc_i = 1'b0;
    bus.wbd_stb_i = 1'b0;
    bus.wbd_we_i  = 1'b0;
    bus.wbd_adr_i = 6'd0;
    bus.wbd_dat_i = 32'd0;
    bus.wbd_sel_i = 4'd0;
    bus.reg_rdata = 32'h8268_2501;
    repeat (3) @(negedge mclk);
    check_idle_outputs("reset");
    h_reset = 1'b0;
    @(negedge mclk);

    // 1: write to index 1 with a one-cycle slave.
    wb_xfer(1'b1, 6'h04, 32'h0000_0301);
    check_eq("t1_cs_first", 32'(cs_first), 32'd1);
    check_eq("t1_addr",     32'(addr_seen), 32'd1);
    check_eq("t1_be",       32'(be_seen),   32'hF);
    check_eq("t1_wr",       32'(wr_seen),   32'd1);
    check_eq("t1_wdata",    wd_seen,        32'h0000_0301);
    check_eq("t1_cs_cnt",   32'(cs_cnt),    32'd2);
    check_eq("t1_ack_at",   32'(ack_at),    32'd3);
    check_eq("t1_ack_cnt",  32'(ack_cnt),   32'd1);
    check_eq("t1_err_cnt",  32'(err_cnt),   32'd0);
    check_eq("t1_slv_acks", 32'(sack_cnt),  32'd1);
    check_eq("t1_dat_kept", bus.wbd_dat_o,  32'd0);

    // 2: read index 0.
    wb_xfer(1'b0, 6'h00, 32'd0);
    check_eq("t2_wr",      32'(wr_seen),  32'd0);
    check_eq("t2_addr",    32'(addr_seen), 32'd0);
    check_eq("t2_rdata",   rd_seen,       32'h8268_2501);
    check_eq("t2_ack_at",  32'(ack_at),   32'd3);
    check_eq("t2_err_cnt", 32'(err_cnt),  32'd0);

    // Boundary: last valid index (11).
    bus.reg_rdata = 32'h1234_5678;
    wb_xfer(1'b0, 6'h2C, 32'd0);
    check_eq("b11_addr",    32'(addr_seen), 32'd11);
    check_eq("b11_rdata",   rd_seen,        32'h1234_5678);
    check_eq("b11_ack_cnt", 32'(ack_cnt),   32'd1);
    check_eq("b11_err_cnt", 32'(err_cnt),   32'd0);

    // 3: first invalid index (12).
    wb_xfer(1'b0, 6'h30, 32'd0);
    check_eq("t3_err_at",  32'(err_at),  32'd1);
    check_eq("t3_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("t3_cs_cnt",  32'(cs_cnt),  32'd0);
    check_eq("t3_ack_cnt", 32'(ack_cnt), 32'd0);
    check_eq("t3_dat_kept", bus.wbd_dat_o, 32'h1234_5678);

    // 4: absent slave, timeout after 4 REQ cycles.
    slave_en = 1'b0;
    wb_xfer(1'b0, 6'h08, 32'd0);
    check_eq("t4_cs_first", 32'(cs_first), 32'd1);
    check_eq("t4_cs_cnt",   32'(cs_cnt),   32'd4);
    check_eq("t4_err_at",   32'(err_at),   32'd5);
    check_eq("t4_err_cnt",  32'(err_cnt),  32'd1);
    check_eq("t4_ack_cnt",  32'(ack_cnt),  32'd0);
    slave_en = 1'b1;

    // 5: master drops cyc while in REQ.
    clr_obs();
    bus.wbd_cyc_i = 1'b1;
    bus.wbd_stb_i = 1'b1;
    bus.wbd_we_i  = 1'b0;
    bus.wbd_adr_i = 6'h04;
    sample(1);
    bus.wbd_cyc_i = 1'b0;
    bus.wbd_stb_i = 1'b0;
    for (int i = 2; i <= 8; i++) sample(i);
    check_eq("t5_cs_cnt",   32'(cs_cnt),   32'd2);
    check_eq("t5_slv_acks", 32'(sack_cnt), 32'd1);
    check_eq("t5_ack_cnt",  32'(ack_cnt),  32'd0);
    check_eq("t5_err_cnt",  32'(err_cnt),  32'd0);
    wb_xfer(1'b1, 6'h0C, 32'hA5A5_0003);
    check_eq("t5_next_ack_at", 32'(ack_at), 32'd3);
    check_eq("t5_next_addr",   32'(addr_seen), 32'd3);

    // 6: reset while reg_cs is high.
    slave_en = 1'b0;
    clr_obs();
    bus.wbd_cyc_i = 1'b1;
    bus.wbd_stb_i = 1'b1;
    bus.wbd_we_i  = 1'b1;
    bus.wbd_adr_i = 6'h10;
    bus.wbd_dat_i = 32'hFFFF_FFFF;
    sample(1);
    sample(2);
    check_eq("t6_cs_before", 32'(bus.reg_cs), 32'd1);
    h_reset = 1'b1;
    bus.wbd_cyc_i = 1'b0;
    bus.wbd_stb_i = 1'b0;
    @(negedge mclk);
    check_idle_outputs("t6_rst");
    h_reset  = 1'b0;
    slave_en = 1'b1;
    clr_obs();
    for (int i = 1; i <= 6; i++) sample(i);
    check_eq("t6_no_ack", 32'(ack_cnt), 32'd0);
    check_eq("t6_no_err", 32'(err_cnt), 32'd0);
    check_eq("t6_no_cs",  32'(cs_cnt),  32'd0);
    wb_xfer(1'b1, 6'h2C, 32'h0000_00AA);
    check_eq("t6_next_ack_at", 32'(ack_at),  32'd3);
    check_eq("t6_next_cs_cnt", 32'(cs_cnt),  32'd2);
    check_eq("t6_next_wdata",  wd_seen,      32'h0000_00AA);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ack/err exclusivity is sampled on every observed cycle.
  final begin
    if (both_cnt != 0) $display("FAIL ack_err_overlap: got %0d expected 0", both_cnt);
  end

endmodule
